// File: rtl/seq_alu.sv
// Multi-cycle 16-bit ALU: single-cycle ADD/SUB, iterative shift-add MUL and
// restoring DIV, driven by a level start/done handshake.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_low,
  output logic [WIDTH-1:0] result_high,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  // Handshake: start is a level request held until done is seen; done is a
  // level held until start is sampled low, after which the block returns to
  // IDLE and may accept again on the following edge.

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   opb_q;
  logic [2*WIDTH-1:0] acc_q;

  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH-1:0]   fast_lo_d;
  logic [WIDTH-1:0]   fast_hi_d;
  logic               is_iter_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_d;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    fast_lo_d = '0;
    fast_hi_d = '0;
    is_iter_d = 1'b0;
    case (opcode)
      OP_ADD: begin
        fast_lo_d = sum_w[WIDTH-1:0];
        fast_hi_d = WIDTH'(sum_w[WIDTH]);
      end
      OP_SUB: begin
        fast_lo_d = diff_w[WIDTH-1:0];
        fast_hi_d = WIDTH'(diff_w[WIDTH]);
      end
      OP_MUL: is_iter_d = 1'b1;
      OP_DIV: begin
        if (b == '0) begin
          fast_lo_d = '1;
          fast_hi_d = a;
        end else begin
          is_iter_d = 1'b1;
        end
      end
      default: begin
        fast_lo_d = '0;
        fast_hi_d = '0;
      end
    endcase
  end

  // MUL: acc holds {partial product high, multiplier}; add then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // DIV: acc holds {remainder, dividend/quotient}; quotient bits enter at LSB.
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, opb_q};
  assign div_next  = div_trial[WIDTH+1] ?
                     {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0} :
                     {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign acc_d = (op_q == OP_DIV) ? div_next : mul_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      result_low  <= '0;
      result_high <= '0;
      done        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q  <= opcode;
            opb_q <= b;
            if (is_iter_d) begin
              acc_q   <= {{WIDTH{1'b0}}, a};
              cnt_q   <= '0;
              state_q <= S_BUSY;
            end else begin
              result_low  <= fast_lo_d;
              result_high <= fast_hi_d;
              done        <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_low  <= acc_d[WIDTH-1:0];
            result_high <= acc_d[2*WIDTH-1:WIDTH];
            done        <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (!start) begin
            done    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dbg_state_o = state_q;

endmodule
